activation: RTL and testbench

Per-node activation stage sitting directly downstream of a `node` MAC unit. Forward: takes the node's 16-bit signed Q8.8 product and produces an 8-bit unsigned Q0.8 activation for the next layer's operand bus. Training: takes the 16-bit error returned from the next layer and produces the 16-bit delta the node consumes, gated by the activation derivative at the stored argument.

---
 rtl/activation_pkg.sv | 52 +++++
 rtl/activation_if.sv | 54 +++++
 rtl/activation.sv | 90 +++++++++
 tb/tb_activation.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_pkg.sv
// Shared types and helpers for the activation stage.
// Holds the fixed-point width, the 16-bit product/delta and 8-bit activation types,
// the stage state enum, and the clamp / derivative-gating functions so the next layer
// can reuse the same arithmetic.
// Optional feature macro: ACTIVATION_LEAKY_EN (consumed by rtl/activation.sv).
package activation_pkg;

    localparam int unsigned W = 8;

    // Signed Q8.8 product from the node, also used for error and delta.
    typedef logic signed [15:0] prod_t;
    // Unsigned Q0.8 activation.
    typedef logic [W-1:0] act_t;

    typedef enum logic [1:0] {
        StIdle,
        StRes,
        StErr,
        StDel
    } state_t;

    // Saturating clamp of the product into [0, 255].
    function automatic act_t clamp_arg(input prod_t arg);
        act_t res;
        if (arg < prod_t'(0)) begin
            res = '0;
        end else if (arg > prod_t'(255)) begin
            res = '1;
        end else begin
            res = arg[W-1:0];
        end
        return res;
    endfunction

    // Error gated by the activation derivative at the stored argument.
    // Linear region passes the error, saturated region blocks it, negative region
    // blocks it or passes an arithmetically shifted copy when leaky.
    function automatic prod_t gate_delta(input prod_t arg, input prod_t err,
                                         input logic leaky, input logic [3:0] shift);
        prod_t res;
        res = '0;
        if (arg < prod_t'(0)) begin
            if (leaky) begin
                res = err >>> shift;
            end
        end else if (arg <= prod_t'(255)) begin
            res = err;
        end
        return res;
    endfunction

endpackage

// File: rtl/activation_if.sv
// Handshake bundle between a node, its activation stage and the next layer.
// Channels: argument (node -> stage), result (stage -> next layer),
// error (next layer -> stage), delta (stage -> node), plus the train mode bit.
// Modports: slave = activation stage view, master = environment view.
interface activation_if;
    import activation_pkg::*;

    logic  train;
    logic  argument_valid;
    prod_t argument_data;
    logic  argument_ready;
    logic  result_valid;
    act_t  result_data;
    logic  result_ready;
    logic  error_valid;
    prod_t error_data;
    logic  error_ready;
    logic  delta_valid;
    prod_t delta_data;
    logic  delta_ready;

    modport slave (
        input  train,
        input  argument_valid,
        input  argument_data,
        output argument_ready,
        output result_valid,
        output result_data,
        input  result_ready,
        input  error_valid,
        input  error_data,
        output error_ready,
        output delta_valid,
        output delta_data,
        input  delta_ready
    );

    modport master (
        output train,
        output argument_valid,
        output argument_data,
        input  argument_ready,
        input  result_valid,
        input  result_data,
        output result_ready,
        output error_valid,
        output error_data,
        input  error_ready,
        input  delta_valid,
        input  delta_data,
        output delta_ready
    );

endinterface

// File: rtl/activation.sv
// Per-node activation stage downstream of a node MAC.
// Forward: clamps the signed Q8.8 product to an unsigned Q0.8 activation.
// Training: gates the returned error by the activation derivative at the stored
// argument and hands the resulting delta back to the node.
// Ports:
//   clock - clock
//   reset - synchronous, active-high
//   bus   - activation_if.slave (argument/result/error/delta handshakes, train)
// Parameter LEAK: right shift applied to error in the negative region (1..15).
// Macro ACTIVATION_LEAKY_EN: when defined the negative region passes error >>> LEAK,
// otherwise it yields zero.
module activation
    import activation_pkg::*;
#(
    parameter int unsigned LEAK = 3
) (
    input logic        clock,
    input logic        reset,
    activation_if.slave bus
);

`ifdef ACTIVATION_LEAKY_EN
    localparam logic LeakyEn = 1'b1;
`else
    localparam logic LeakyEn = 1'b0;
`endif
    localparam logic [3:0] LeakShift = 4'(LEAK);

    state_t state_q, state_d;
    prod_t  arg_q, arg_d;
    act_t   result_q, result_d;
    prod_t  delta_q, delta_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            arg_q    <= '0;
            result_q <= '0;
            delta_q  <= '0;
        end else begin
            state_q  <= state_d;
            arg_q    <= arg_d;
            result_q <= result_d;
            delta_q  <= delta_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        arg_d    = arg_q;
        result_d = result_q;
        delta_d  = delta_q;
        unique case (state_q)
            StIdle: begin
                if (bus.argument_valid) begin
                    arg_d    = bus.argument_data;
                    result_d = clamp_arg(bus.argument_data);
                    state_d  = StRes;
                end
            end
            StRes: begin
                // train is only meaningful at the result handshake.
                if (bus.result_ready) begin
                    state_d = bus.train ? StErr : StIdle;
                end
            end
            StErr: begin
                if (bus.error_valid) begin
                    delta_d = gate_delta(arg_q, bus.error_data, LeakyEn, LeakShift);
                    state_d = StDel;
                end
            end
            StDel: begin
                if (bus.delta_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Readies and valids are pure decodes of the state register.
    assign bus.argument_ready = (state_q == StIdle);
    assign bus.result_valid   = (state_q == StRes);
    assign bus.error_ready    = (state_q == StErr);
    assign bus.delta_valid    = (state_q == StDel);
    assign bus.result_data    = result_q;
    assign bus.delta_data     = delta_q;

endmodule

// File: tb/tb_activation.sv
// Self-checking bench for the activation stage: directed cases with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level reference model.
module tb_activation;

    localparam int unsigned LEAK = 3;
`ifdef ACTIVATION_LEAKY_EN
    localparam bit Leaky = 1'b1;
`else
    localparam bit Leaky = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    activation_if bus ();

    activation #(
        .LEAK (LEAK)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference activation and delta, in plain integer arithmetic.
    function automatic logic [7:0] ref_act(input logic [15:0] a);
        int v;
        v = int'($signed(a));
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    function automatic logic [15:0] ref_delta(input logic [15:0] a, input logic [15:0] e);
        int v;
        int ev;
        v  = int'($signed(a));
        ev = int'($signed(e));
        if (v > 255) return 16'h0000;
        if (v >= 0) return e;
        if (!Leaky) return 16'h0000;
        return 16'(ev >>> LEAK);
    endfunction

    // Transaction-level model: which token is outstanding and its values.
    bit          m_res_pend, m_err_wait, m_del_pend;
    logic [15:0] m_arg;
    logic [7:0]  m_res;
    logic [15:0] m_del;

    initial begin
        m_res_pend = 0; m_err_wait = 0; m_del_pend = 0;
        m_arg = '0; m_res = '0; m_del = '0;
        @(posedge clock);
        forever begin
            @(negedge clock);
            check("argument_ready", 16'(bus.argument_ready),
                  16'(!(m_res_pend || m_err_wait || m_del_pend)));
            check("result_valid", 16'(bus.result_valid), 16'(m_res_pend));
            check("result_data", 16'(bus.result_data), 16'(m_res));
            check("error_ready", 16'(bus.error_ready), 16'(m_err_wait));
            check("delta_valid", 16'(bus.delta_valid), 16'(m_del_pend));
            check("delta_data", bus.delta_data, m_del);
            // Inputs are stable here until after the next rising edge.
            if (reset) begin
                m_res_pend = 0; m_err_wait = 0; m_del_pend = 0;
                m_arg = '0; m_res = '0; m_del = '0;
            end else if (m_res_pend) begin
                if (bus.result_ready) begin
                    m_res_pend = 0;
                    m_err_wait = bus.train;
                end
            end else if (m_err_wait) begin
                if (bus.error_valid) begin
                    m_err_wait = 0;
                    m_del_pend = 1;
                    m_del      = ref_delta(m_arg, bus.error_data);
                end
            end else if (m_del_pend) begin
                if (bus.delta_ready) m_del_pend = 0;
            end else if (bus.argument_valid) begin
                m_arg      = bus.argument_data;
                m_res      = ref_act(bus.argument_data);
                m_res_pend = 1;
            end
        end
    end

    // Bounded wait for a DUT output: 0=argument_ready 1=result_valid 2=error_ready 3=delta_valid.
    task automatic wait_sig(input int which, input string name);
        int  n;
        logic s;
        n = 0;
        forever begin
            case (which)
                0: s = bus.argument_ready;
                1: s = bus.result_valid;
                2: s = bus.error_ready;
                default: s = bus.delta_valid;
            endcase
            if (s) break;
            if (n >= 50) begin
                checks++;
                failures++;
                $display("FAIL timeout_%s actual=0 required=1 at %0t", name, $time);
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic idle_inputs();
        bus.train          = 1'b0;
        bus.argument_valid = 1'b0;
        bus.argument_data  = '0;
        bus.result_ready   = 1'b0;
        bus.error_valid    = 1'b0;
        bus.error_data     = '0;
        bus.delta_ready    = 1'b0;
    endtask

    // One full token; returns the captured activation and delta.
    task automatic do_txn(input logic [15:0] a, input logic tr, input logic [15:0] e,
                          input int ddly, output logic [7:0] r, output logic [15:0] d);
        d = '0;
        bus.train          = tr;
        bus.argument_data  = a;
        bus.argument_valid = 1'b1;
        wait_sig(0, "argument_ready");
        step();
        bus.argument_valid = 1'b0;
        wait_sig(1, "result_valid");
        r = bus.result_data;
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        if (tr) begin
            bus.error_data  = e;
            bus.error_valid = 1'b1;
            wait_sig(2, "error_ready");
            step();
            bus.error_valid = 1'b0;
            wait_sig(3, "delta_valid");
            d = bus.delta_data;
            for (int i = 0; i < ddly; i++) begin
                check("delta_hold_valid", 16'(bus.delta_valid), 16'h1);
                check("delta_hold_data", bus.delta_data, d);
                check("delta_hold_arg_ready", 16'(bus.argument_ready), 16'h0);
                step();
            end
            bus.delta_ready = 1'b1;
            step();
            bus.delta_ready = 1'b0;
        end
        bus.train = 1'b0;
    endtask

    function automatic logic [15:0] pick_arg();
        case ($urandom_range(3))
            0:       return 16'($urandom_range(255));
            1:       return 16'h8000 | 16'($urandom);
            2:       return 16'h0100 + 16'($urandom_range(16'h7e00));
            default: return 16'($urandom);
        endcase
    endfunction

    logic [7:0]  r;
    logic [15:0] d;

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check("rst_result_valid", 16'(bus.result_valid), 16'h0);
        check("rst_delta_valid", 16'(bus.delta_valid), 16'h0);
        check("rst_result_data", 16'(bus.result_data), 16'h0);
        check("rst_delta_data", bus.delta_data, 16'h0);
        check("rst_argument_ready", 16'(bus.argument_ready), 16'h1);
        reset = 1'b0;
        step();

        // Linear region, inference only.
        do_txn(16'h0080, 1'b0, 16'h0, 0, r, d);
        check("t1_result", 16'(r), 16'h0080);
        check("t1_error_ready", 16'(bus.error_ready), 16'h0);
        check("t1_argument_ready", 16'(bus.argument_ready), 16'h1);

        // Saturated region blocks the gradient.
        do_txn(16'h0200, 1'b1, 16'h0100, 0, r, d);
        check("t2_result", 16'(r), 16'h00ff);
        check("t2_delta", d, 16'h0000);

        // Negative region.
        do_txn(16'hff00, 1'b1, 16'h0100, 0, r, d);
        check("t3_result", 16'(r), 16'h0000);
        check("t3_delta", d, Leaky ? 16'h0020 : 16'h0000);

        // Linear region with delta backpressure.
        do_txn(16'h0010, 1'b1, 16'hff80, 4, r, d);
        check("t4_result", 16'(r), 16'h0010);
        check("t4_delta", d, 16'hff80);
        check("t4_argument_ready", 16'(bus.argument_ready), 16'h1);

        // Result backpressure with a second argument waiting.
        bus.argument_data  = 16'h00ff;
        bus.argument_valid = 1'b1;
        step();
        bus.argument_data = 16'h0042;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", 16'(bus.result_valid), 16'h1);
            check("t5_hold_data", 16'(bus.result_data), 16'h00ff);
            check("t5_hold_arg_ready", 16'(bus.argument_ready), 16'h0);
            step();
        end
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        check("t5_back_idle", 16'(bus.argument_ready), 16'h1);
        check("t5_result_valid_low", 16'(bus.result_valid), 16'h0);
        step();
        bus.argument_valid = 1'b0;
        check("t5_second_valid", 16'(bus.result_valid), 16'h1);
        check("t5_second_data", 16'(bus.result_data), 16'h0042);
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;

        // Reset while waiting for the error, with error_valid high.
        bus.train          = 1'b1;
        bus.argument_data  = 16'h0010;
        bus.argument_valid = 1'b1;
        step();
        bus.argument_valid = 1'b0;
        bus.result_ready   = 1'b1;
        step();
        bus.result_ready = 1'b0;
        bus.train        = 1'b0;
        check("t6_in_err", 16'(bus.error_ready), 16'h1);
        bus.error_data  = 16'h0123;
        bus.error_valid = 1'b1;
        reset           = 1'b1;
        step();
        reset = 1'b0;
        check("t6_delta_valid", 16'(bus.delta_valid), 16'h0);
        check("t6_argument_ready", 16'(bus.argument_ready), 16'h1);
        step();
        bus.error_valid = 1'b0;
        check("t6_delta_valid_after", 16'(bus.delta_valid), 16'h0);
        check("t6_argument_ready_after", 16'(bus.argument_ready), 16'h1);

        // Randomized traffic, including valids outside their window and stray resets.
        for (int i = 0; i < 3000; i++) begin
            bus.train          = 1'($urandom_range(1));
            bus.argument_valid = ($urandom_range(99) < 50);
            bus.argument_data  = pick_arg();
            bus.result_ready   = ($urandom_range(99) < 60);
            bus.error_valid    = ($urandom_range(99) < 50);
            bus.error_data     = 16'($urandom);
            bus.delta_ready    = ($urandom_range(99) < 60);
            reset              = ($urandom_range(255) == 0);
            step();
        end
        idle_inputs();
        reset = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
